// File: rtl/image_block_sequencer.sv
// rtl/image_block_sequencer.sv - block-raster line read/write request sequencer for image copy/flip/rotate
// Optional handshake timeout: define IMAGE_BLOCK_SEQ_TIMEOUT_EN.
module image_block_sequencer #(
  parameter int ADDR_W          = 32,
  parameter int BLOCK_SIZE      = 120,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int CNT_W           = 5,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              BeginRotation,
  input  logic [ADDR_W-1:0] InputImageAddress,
  input  logic [ADDR_W-1:0] OutputImageAddress,
  input  logic [1:0]        RotationType,
  input  logic [CNT_W-1:0]  NumBlocksX,
  input  logic [CNT_W-1:0]  NumBlocksY,
  output logic              MstRdReq,
  output logic              MstWrReq,
  output logic [ADDR_W-1:0] MstAddr,
  output logic [19:0]       MstLength,
  input  logic              MstCmdAck,
  input  logic              MstCmplt,
  output logic              Busy,
  output logic              RotationDone,
  output logic              Error
);

  localparam int LINE_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(BLOCK_SIZE - 1);
  localparam logic [ADDR_W-1:0] B_A   = ADDR_W'(BLOCK_SIZE);
  localparam logic [ADDR_W-1:0] BPP_A = ADDR_W'(BYTES_PER_PIXEL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_CMPLT,
    S_WR_REQ,
    S_WR_CMPLT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  bx_q, bx_d, by_q, by_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] in_q, in_d, out_q, out_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  nx_q, nx_d, ny_q, ny_d;

  logic              rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              go_rd, go_wr;

  logic [ADDR_W-1:0] width_a, height_a, row_a, col_a, col_mir_a;
  logic [ADDR_W-1:0] wr_row_a, wr_col_a, rd_addr, wr_addr;

`ifdef IMAGE_BLOCK_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             waiting, tmo_hit;

  assign waiting = (state_q == S_RD_REQ) || (state_q == S_RD_CMPLT) ||
                   (state_q == S_WR_REQ) || (state_q == S_WR_CMPLT);
  assign tmo_hit = waiting && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state and next-output logic of the sequencing FSM
  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    line_d   = line_q;
    in_d     = in_q;
    out_d    = out_q;
    mode_d   = mode_q;
    nx_d     = nx_q;
    ny_d     = ny_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    go_rd    = 1'b0;
    go_wr    = 1'b0;
`ifdef IMAGE_BLOCK_SEQ_TIMEOUT_EN
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // busy_q is still high in the cycle right after DONE; a start there is ignored
        if (BeginRotation && !busy_q) begin
          in_d   = InputImageAddress;
          out_d  = OutputImageAddress;
          mode_d = RotationType;
          nx_d   = NumBlocksX;
          ny_d   = NumBlocksY;
          bx_d   = '0;
          by_d   = '0;
          line_d = '0;
`ifdef IMAGE_BLOCK_SEQ_TIMEOUT_EN
          err_d  = 1'b0;
`endif
          if (NumBlocksX == '0 || NumBlocksY == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD_REQ;
            go_rd   = 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        if (MstCmdAck) begin
          rd_req_d = 1'b0;
          state_d  = S_RD_CMPLT;
        end
      end
      S_RD_CMPLT: begin
        if (MstCmplt) begin
          if (line_q != LAST_LINE) begin
            line_d  = line_q + LINE_W'(1);
            state_d = S_RD_REQ;
            go_rd   = 1'b1;
          end else begin
            line_d  = '0;
            state_d = S_WR_REQ;
            go_wr   = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        if (MstCmdAck) begin
          wr_req_d = 1'b0;
          state_d  = S_WR_CMPLT;
        end
      end
      S_WR_CMPLT: begin
        if (MstCmplt) begin
          if (line_q != LAST_LINE) begin
            line_d  = line_q + LINE_W'(1);
            state_d = S_WR_REQ;
            go_wr   = 1'b1;
          end else begin
            line_d = '0;
            if (bx_q != nx_q - CNT_W'(1)) begin
              bx_d    = bx_q + CNT_W'(1);
              state_d = S_RD_REQ;
              go_rd   = 1'b1;
            end else if (by_q != ny_q - CNT_W'(1)) begin
              bx_d    = '0;
              by_d    = by_q + CNT_W'(1);
              state_d = S_RD_REQ;
              go_rd   = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (go_rd) rd_req_d = 1'b1;
    if (go_wr) wr_req_d = 1'b1;
`ifdef IMAGE_BLOCK_SEQ_TIMEOUT_EN
    // A stalled handshake abandons the job and reports through Error + RotationDone
    if (tmo_hit) begin
      state_d  = S_DONE;
      rd_req_d = 1'b0;
      wr_req_d = 1'b0;
      go_rd    = 1'b0;
      go_wr    = 1'b0;
      err_d    = 1'b1;
    end
`endif
  end

  // Line addresses for the position being entered; row/column mirroring per rotation mode
  always_comb begin
    width_a   = ADDR_W'(nx_d) * B_A;
    height_a  = ADDR_W'(ny_d) * B_A;
    row_a     = ADDR_W'(by_d) * B_A + ADDR_W'(line_d);
    col_a     = ADDR_W'(bx_d) * B_A;
    col_mir_a = (ADDR_W'(nx_d) - ADDR_W'(bx_d) - ADDR_W'(1)) * B_A;
    wr_row_a  = mode_d[1] ? (height_a - ADDR_W'(1) - row_a) : row_a;
    wr_col_a  = mode_d[0] ? col_mir_a : col_a;
    rd_addr   = in_d  + (row_a    * width_a + col_a)    * BPP_A;
    wr_addr   = out_d + (wr_row_a * width_a + wr_col_a) * BPP_A;
  end

  // Address only moves when a new request is raised, so it never changes under a live request
  always_comb begin
    addr_d = addr_q;
    if (go_rd) begin
      addr_d = rd_addr;
    end else if (go_wr) begin
      addr_d = wr_addr;
    end
  end

  // Busy covers the whole job including the RotationDone cycle; done pulses on leaving DONE
  always_comb begin
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    done_d = (state_q == S_DONE);
  end

`ifdef IMAGE_BLOCK_SEQ_TIMEOUT_EN
  // Per-state wait counter, restarted on every state change
  always_comb begin
    tmo_d = '0;
    if (state_d == state_q && waiting) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end
`endif

  // State, counters, latched job parameters and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      bx_q     <= '0;
      by_q     <= '0;
      line_q   <= '0;
      in_q     <= '0;
      out_q    <= '0;
      mode_q   <= '0;
      nx_q     <= '0;
      ny_q     <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      line_q   <= line_d;
      in_q     <= in_d;
      out_q    <= out_d;
      mode_q   <= mode_d;
      nx_q     <= nx_d;
      ny_q     <= ny_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef IMAGE_BLOCK_SEQ_TIMEOUT_EN
  // Timeout counter and sticky error flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign Error = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign Error      = 1'b0;
`endif

  assign MstRdReq     = rd_req_q;
  assign MstWrReq     = wr_req_q;
  assign MstAddr      = addr_q;
  assign MstLength    = 20'(BLOCK_SIZE * BYTES_PER_PIXEL);
  assign Busy         = busy_q;
  assign RotationDone = done_q;

endmodule

// File: doc/image_block_sequencer.md
IMAGE_BLOCK_SEQUENCER -- requirements
Module: image_block_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32: width of all byte addresses.
REQ-002 Parameter BLOCK_SIZE, default 120: pixels per block edge (lines per block, pixels per line request).
REQ-003 Parameter BYTES_PER_PIXEL, default 2: bytes per pixel.
REQ-004 Parameter CNT_W, default 5: width of block-count inputs and block counters.
REQ-005 Parameter TIMEOUT_CYCLES, default 1024: handshake timeout limit; used only when IMAGE_BLOCK_SEQ_TIMEOUT_EN is defined.
REQ-006 Ports: Clk  in  1  sole clock; all logic on posedge Clk.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 BeginRotation  in  1  start pulse, sampled in IDLE only.
REQ-009 InputImageAddress  in  ADDR_W  source image base byte address.
REQ-010 OutputImageAddress  in  ADDR_W  destination image base byte address.
REQ-011 RotationType  in  2  00 copy, 01 horizontal flip, 10 vertical flip, 11 rotate-180.
REQ-012 NumBlocksX / NumBlocksY  in  CNT_W each  image width / height in blocks.
REQ-013 MstRdReq / MstWrReq  out  1 each  line read / line write request.
REQ-014 MstAddr  out  ADDR_W  request byte address; MstLength  out  20  constant BLOCK_SIZE*BYTES_PER_PIXEL.
REQ-015 MstCmdAck / MstCmplt  in  1 each  bus command accepted / transfer complete.
REQ-016 Busy  out  1;  RotationDone  out  1 (one-cycle pulse);  Error  out  1.

Function
REQ-017 States: IDLE, RD_REQ, RD_CMPLT, WR_REQ, WR_CMPLT, DONE; all outputs registered.
REQ-018 IDLE with BeginRotation=1: latch addresses, RotationType, NumBlocksX/Y; clear bx, by, line counters; next state RD_REQ; Busy=1 from next cycle until IDLE.
REQ-019 BeginRotation=1 with NumBlocksX=0 or NumBlocksY=0: IDLE -> DONE directly, no requests issued.
REQ-020 RD_REQ: MstRdReq=1 and MstAddr valid; on MstCmdAck=1, MstRdReq=0 on next cycle and state -> RD_CMPLT.
REQ-021 RD_CMPLT: MstCmplt ignored elsewhere; on MstCmplt=1, line<BLOCK_SIZE-1 -> line+1, RD_REQ; else line=0, WR_REQ.
REQ-022 WR_REQ/WR_CMPLT: same handshake as REQ-020/021 with MstWrReq; after last write line, advance block raster order (bx inner, wraps at NumBlocksX-1, then by+1) -> RD_REQ, or DONE after block (NX-1,NY-1).
REQ-023 Read address: In + ((by*B+line)*W + bx*B)*BPP, with B=BLOCK_SIZE, W=NumBlocksX*B, H=NumBlocksY*B.
REQ-024 Write row R / column C per mode: copy R=by*B+line, C=bx*B; hflip R=by*B+line, C=(NX-1-bx)*B; vflip R=H-1-(by*B+line), C=bx*B; rot180 R=H-1-(by*B+line), C=(NX-1-bx)*B; address Out+(R*W+C)*BPP.
REQ-025 Address arithmetic is unsigned, truncated modulo 2^ADDR_W.
REQ-026 MstAddr and MstRdReq/MstWrReq change together; MstRdReq and MstWrReq are never both 1.
REQ-027 DONE: RotationDone=1 for exactly one cycle, Busy=0 on the following cycle, next state IDLE.
REQ-028 BeginRotation while Busy=1 is ignored; input changes while Busy=1 have no effect.

Reset
REQ-029 Reset=1 at a clock edge: state IDLE, all counters 0, MstRdReq=MstWrReq=0, MstAddr=0, Busy=0, RotationDone=0, Error=0; an operation in progress is abandoned without RotationDone.

Configuration
REQ-030 Macro IMAGE_BLOCK_SEQ_TIMEOUT_EN defined: a cycle counter, cleared on each state entry, runs in RD_REQ/RD_CMPLT/WR_REQ/WR_CMPLT; reaching TIMEOUT_CYCLES drops requests, sets Error=1, goes to DONE; Error clears on next accepted BeginRotation.
REQ-031 Macro undefined: no timeout logic, handshake waits indefinitely, Error tied to 0.

Verification (B=4, BPP=2, NX=NY=2, In=0x1000, Out=0x8000, ack and cmplt 1 cycle after request)
REQ-032 Copy: Begin -> 16 reads, 16 writes; block(1,0) line 0 read 0x1008 and write 0x8008; one RotationDone pulse.
REQ-033 Hflip/vflip/rot180: block(0,0) line 0 write addresses 0x8008 / 0x8070 / 0x8078.
REQ-034 MstCmdAck held 0 for 5 cycles: MstRdReq stays 1 with stable MstAddr; MstCmplt pulse during RD_REQ ignored.
REQ-035 NumBlocksX=0: Begin -> RotationDone 2 cycles later, no requests.
REQ-036 Reset during 3rd write: all outputs 0 next cycle, no RotationDone; new Begin restarts at 0x1000.
REQ-037 With IMAGE_BLOCK_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, MstCmdAck never asserted: Error=1 and RotationDone pulse 8 cycles after request; without macro, request held indefinitely.
